// File: rtl/imm_narrow_packer_pkg.sv
// Shared constants and types for the immediate narrowing packer.
//   DIN_W / FIELD_W / GROUP : operand width, immediate field width, fields per packed group
//   OUT_BYTES               : bytes emitted per group (GROUP*FIELD_W / DIN_W)
//   state_e                 : packer FSM state encoding
//   SAT_*                   : saturation values for out-of-range operands
package imm_narrow_packer_pkg;

  localparam int unsigned DIN_W     = 8;
  localparam int unsigned FIELD_W   = 6;
  localparam int unsigned GROUP     = 4;
  localparam int unsigned ACC_W     = GROUP * FIELD_W;
  localparam int unsigned OUT_BYTES = ACC_W / DIN_W;
  // cnt must hold 0..GROUP inclusive.
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned BIDX_W    = 2;

  localparam logic [FIELD_W-1:0] SAT_SPOS = 6'h1F;
  localparam logic [FIELD_W-1:0] SAT_SNEG = 6'h20;
  localparam logic [FIELD_W-1:0] SAT_U    = 6'h3F;

  typedef enum logic [0:0] {
    StFill = 1'b0,
    StEmit = 1'b1
  } state_e;

endpackage

// File: rtl/imm_narrow_sat.sv
// Combinational narrowing of one 8-bit operand to a 6-bit immediate field.
//   din       : operand
//   sign_mode : 1 = signed narrowing, 0 = unsigned
//   dout      : narrowed (possibly saturated) field
//   ovf       : operand did not fit and was saturated
module imm_narrow_sat
  import imm_narrow_packer_pkg::*;
(
  input  logic [DIN_W-1:0]   din,
  input  logic               sign_mode,
  output logic [FIELD_W-1:0] dout,
  output logic               ovf
);

  logic fits;

  always_comb begin
    if (sign_mode) begin
      // Signed value fits when the top three bits are all copies of the sign.
      fits = (din[7] == din[6]) && (din[6] == din[5]);
      dout = fits ? din[FIELD_W-1:0] : (din[7] ? SAT_SNEG : SAT_SPOS);
    end else begin
      fits = (din[7:6] == 2'b00);
      dout = fits ? din[FIELD_W-1:0] : SAT_U;
    end
    ovf = ~fits;
  end

endmodule

// File: rtl/imm_narrow_packer.sv
// Narrows 8-bit operands to 6-bit immediates and packs GROUP fields into a byte stream.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      : operand stream; sign_mode sampled per accepted operand
//   flush                          : emit a partial group, zero-padded
//   out_valid/out_ready/out_data   : packed byte stream, byte 0 first
//   out_last                       : final byte of a group
//   out_fields                     : valid fields in the group being emitted
//   ovf_sticky, sat_count, clr_ovf : saturation reporting and clear
module imm_narrow_packer
  import imm_narrow_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] in_data,
  input  logic             sign_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIN_W-1:0] out_data,
  output logic             out_last,
  output logic [2:0]       out_fields,
  output logic             ovf_sticky,
  input  logic             clr_ovf,
  output logic [7:0]       sat_count
);

  localparam logic [BIDX_W-1:0] LastByte = BIDX_W'(OUT_BYTES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_after;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2:0]          fields_q, fields_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          sat_q, sat_d;

  logic                accept;
  logic                sat_ev;
  logic [FIELD_W-1:0]  field;
  logic                field_ovf;
  logic [DIN_W-1:0]    cur_byte;

  imm_narrow_sat u_sat (
    .din       (in_data),
    .sign_mode (sign_mode),
    .dout      (field),
    .ovf       (field_ovf)
  );

  assign accept    = in_valid && (state_q == StFill);
  assign sat_ev    = accept && field_ovf;
  assign cnt_after = cnt_q + {{(CNT_W-1){1'b0}}, accept};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    fields_d   = fields_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          for (int i = 0; i < GROUP; i++) begin
            if (cnt_q == CNT_W'(i)) acc_d[i*FIELD_W +: FIELD_W] = field;
          end
          cnt_d = cnt_after;
        end
        // A same-cycle accept counts toward the flushed group.
        if ((cnt_after == CNT_W'(GROUP)) || (flush && (cnt_after != '0))) begin
          state_d    = StEmit;
          byte_idx_d = '0;
          fields_d   = cnt_after;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (byte_idx_q == LastByte) begin
            state_d    = StFill;
            cnt_d      = '0;
            acc_d      = '0;
            byte_idx_d = '0;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // A clear coinciding with a saturating accept keeps the new event.
  always_comb begin
    ovf_d = ovf_q;
    sat_d = sat_q;
    if (clr_ovf) begin
      ovf_d = sat_ev;
      sat_d = {7'd0, sat_ev};
    end else if (sat_ev) begin
      ovf_d = 1'b1;
      if (sat_q != 8'hFF) sat_d = sat_q + 8'd1;
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < OUT_BYTES; b++) begin
      if (byte_idx_q == BIDX_W'(b)) cur_byte = acc_q[b*DIN_W +: DIN_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      acc_q      <= '0;
      fields_q   <= '0;
      ovf_q      <= 1'b0;
      sat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      fields_q   <= fields_d;
      ovf_q      <= ovf_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready   = (state_q == StFill);
  assign out_valid  = (state_q == StEmit);
  assign out_data   = out_valid ? cur_byte : '0;
  assign out_last   = out_valid && (byte_idx_q == LastByte);
  assign out_fields = fields_q;
  assign ovf_sticky = ovf_q;
  assign sat_count  = sat_q;

endmodule

// File: tb/tb_imm_narrow_packer.sv
module tb_imm_narrow_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       sign_mode;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [2:0] out_fields;
  logic       ovf_sticky;
  logic       clr_ovf;
  logic [7:0] sat_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_narrow_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sign_mode  (sign_mode),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_fields (out_fields),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf),
    .sat_count  (sat_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1, so outputs are sampled well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sm);
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    sign_mode = sm;
    tick();
    in_valid  = 1'b0;
  endtask

  // Expects a group already in EMIT with out_ready=1; consumes its three bytes.
  task automatic expect_group(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [2:0] nf);
    logic [7:0] exp_b [3];
    exp_b[0] = b0;
    exp_b[1] = b1;
    exp_b[2] = b2;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp_b[i]});
      check({tag, "_last"}, {31'd0, out_last}, (i == 2) ? 32'd1 : 32'd0);
      check({tag, "_fields"}, {29'd0, out_fields}, {29'd0, nf});
      check({tag, "_inready"}, {31'd0, in_ready}, 32'd0);
      tick();
    end
    check({tag, "_done"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sign_mode = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_fields", {29'd0, out_fields}, 32'd0);
    check("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
    check("rst_sat", {24'd0, sat_count}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: unsigned, all fit
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    expect_group("t1", 8'h81, 8'h30, 8'h10, 3'd4);
    check("t1_ovf", {31'd0, ovf_sticky}, 32'd0);
    check("t1_sat", {24'd0, sat_count}, 32'd0);

    // 2: signed with saturation both directions
    send(8'hFF, 1'b1);
    send(8'h40, 1'b1);
    send(8'h90, 1'b1);
    send(8'h00, 1'b1);
    expect_group("t2", 8'hFF, 8'h07, 8'h02, 3'd2 + 3'd2);
    check("t2_sat", {24'd0, sat_count}, 32'd2);
    check("t2_ovf", {31'd0, ovf_sticky}, 32'd1);

    // 3: partial group via flush, then flush with nothing buffered
    send(8'h05, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_group("t3", 8'h05, 8'h00, 8'h00, 3'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_empty_flush_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("t3_empty_flush_valid2", {31'd0, out_valid}, 32'd0);
    check("t3_empty_flush_ready", {31'd0, in_ready}, 32'd1);

    // 4: backpressure holds the first byte; input is blocked
    out_ready = 1'b0;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h3F, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h15;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_data", {24'd0, out_data}, 32'h10);
      check("t4_hold_last", {31'd0, out_last}, 32'd0);
      check("t4_hold_inready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_group("t4", 8'h10, 8'h08, 8'hFF, 3'd4);

    // 5: reset mid-group discards the partial group and counters
    send(8'h3A, 1'b0);
    send(8'h2B, 1'b0);
    rst_n = 1'b0;
    #2;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    check("t5_rst_fields", {29'd0, out_fields}, 32'd0);
    check("t5_rst_ovf", {31'd0, ovf_sticky}, 32'd0);
    check("t5_rst_sat", {24'd0, sat_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    expect_group("t5", 8'h81, 8'h30, 8'h10, 3'd4);

    // 6: clear coinciding with a saturating accept, then clear alone
    send(8'h80, 1'b0);
    send(8'h80, 1'b0);
    check("t6_sat_pre", {24'd0, sat_count}, 32'd2);
    clr_ovf = 1'b1;
    send(8'hC0, 1'b0);
    clr_ovf = 1'b0;
    check("t6_clr_ev_ovf", {31'd0, ovf_sticky}, 32'd1);
    check("t6_clr_ev_sat", {24'd0, sat_count}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t6_clr_ovf", {31'd0, ovf_sticky}, 32'd0);
    check("t6_clr_sat", {24'd0, sat_count}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_group("t6", 8'hFF, 8'hFF, 8'h03, 3'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
